mem_stage_ctl: RTL

//  MIPS MEM stage between the EX/MEM and MEM/WB registers. Non-memory ops pass

---
 rtl/mem_stage_ctl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_stage_ctl.sv
// mem_stage_ctl: MIPS MEM stage control (handshake, extend, byte enables, traps; LL/SC under MEM_LLSC_EN)
module mem_stage_ctl #(
   parameter int REGADDR_W  = 5,
   parameter int MAX_WAIT   = 15,
   parameter int BIG_ENDIAN = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           mem_op_i,
   input  logic [31:0]          mem_addr_i,
   input  logic [31:0]          mem_sdata_i,
   input  logic [REGADDR_W-1:0] wd_i,
   input  logic                 wreg_i,
   input  logic [31:0]          wdata_i,
   input  logic [31:0]          hi_i,
   input  logic [31:0]          lo_i,
   input  logic                 whilo_i,
   input  logic                 llbit_clr_i,
   input  logic [31:0]          dm_rdata_i,
   input  logic                 dm_ack_i,
   output logic [REGADDR_W-1:0] wd_o,
   output logic                 wreg_o,
   output logic [31:0]          wdata_o,
   output logic [31:0]          hi_o,
   output logic [31:0]          lo_o,
   output logic                 whilo_o,
   output logic                 dm_req_o,
   output logic                 dm_we_o,
   output logic [3:0]           dm_be_o,
   output logic [31:0]          dm_addr_o,
   output logic [31:0]          dm_wdata_o,
   output logic                 stall_req_o,
   output logic                 addr_err_o,
   output logic                 bus_err_o
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      r_state, w_next;
   logic [7:0]  r_cnt;
   logic [31:0] r_ldata;
   logic        r_berr;
   logic w_lb, w_lbu, w_lh, w_lhu, w_lw, w_sb, w_sh, w_sw, w_ll, w_sc;
   logic w_ld, w_st, w_mis, w_scok, w_mem, w_req, w_timeout, w_idle, w_busy, w_done, w_hidx;
   logic [1:0]  w_bidx;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;
   assign w_lb  = mem_op_i == 4'd1;
   assign w_lbu = mem_op_i == 4'd2;
   assign w_lh  = mem_op_i == 4'd3;
   assign w_lhu = mem_op_i == 4'd4;
   assign w_lw  = mem_op_i == 4'd5;
   assign w_sb  = mem_op_i == 4'd6;
   assign w_sh  = mem_op_i == 4'd7;
   assign w_sw  = mem_op_i == 4'd8;
   assign w_ll  = mem_op_i == 4'd9;
   assign w_sc  = mem_op_i == 4'd10;
   assign w_ld  = w_lb | w_lbu | w_lh | w_lhu | w_lw | w_ll;
   assign w_st  = w_sb | w_sh | w_sw | w_sc;
   assign w_mis = ((w_lh | w_lhu | w_sh) & mem_addr_i[0]) | ((w_lw | w_sw | w_ll | w_sc) & |mem_addr_i[1:0]);
`ifdef MEM_LLSC_EN
   logic        r_llbit;
   logic [31:0] r_lladdr;
   assign w_scok = r_llbit && (mem_addr_i == r_lladdr);
   // LL reservation: clear request wins over a same-cycle LL set
   always_ff @(posedge clk) begin
      if (rst) r_llbit <= 1'b0;
      else if (llbit_clr_i) r_llbit <= 1'b0;
      else if (w_done && w_ll && !r_berr) begin
         r_llbit  <= 1'b1;
         r_lladdr <= mem_addr_i;
      end else if (w_done && w_sc) r_llbit <= 1'b0;
   end
`else
   logic w_unused_llclr;
   assign w_unused_llclr = llbit_clr_i;
   assign w_scok = 1'b1;
`endif
   assign w_idle    = r_state == IDLE;
   assign w_busy    = r_state == BUSY;
   assign w_done    = r_state == DONE;
   assign w_mem     = (w_ld | w_st) & !w_mis & !(w_sc & !w_scok);
   assign w_timeout = w_busy && !dm_ack_i && (r_cnt == 8'(MAX_WAIT));
   assign w_req     = !rst && ((w_idle && w_mem) || w_busy);
   assign w_bidx    = (BIG_ENDIAN != 0) ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
   assign w_hidx    = (BIG_ENDIAN != 0) ? ~mem_addr_i[1] : mem_addr_i[1];
   assign w_byte    = 8'(dm_rdata_i >> {w_bidx, 3'b000});
   assign w_half    = 16'(dm_rdata_i >> {w_hidx, 4'b0000});
   assign w_ext     = w_lb  ? {{24{w_byte[7]}}, w_byte} :
                      w_lbu ? {24'b0, w_byte} :
                      w_lh  ? {{16{w_half[15]}}, w_half} :
                      w_lhu ? {16'b0, w_half} : dm_rdata_i;
   // Next state: IDLE issues, BUSY waits for ack or timeout, DONE releases for one cycle
   always_comb begin
      w_next = r_state;
      if (w_idle && w_mem) w_next = BUSY;
      else if (w_busy && (dm_ack_i || w_timeout)) w_next = DONE;
      else if (w_done) w_next = IDLE;
   end
   // State, wait counter, captured load data and timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_berr  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_busy ? r_cnt + 8'd1 : 8'd0;
         r_berr  <= w_timeout;
      end
      if (w_busy && dm_ack_i) r_ldata <= w_ext;
   end
   assign dm_req_o    = w_req;
   assign stall_req_o = w_req;
   assign dm_we_o     = w_req & w_st;
   assign dm_be_o     = !w_req ? 4'b0000 : w_sb ? 4'b0001 << w_bidx : w_sh ? (w_hidx ? 4'b1100 : 4'b0011) : w_st ? 4'b1111 : 4'b0000;
   assign dm_addr_o   = w_req ? {mem_addr_i[31:2], 2'b00} : 32'd0;
   assign dm_wdata_o  = !w_req ? 32'd0 : w_sb ? {4{mem_sdata_i[7:0]}} : w_sh ? {2{mem_sdata_i[15:0]}} : mem_sdata_i;
   assign addr_err_o  = !rst & w_mis;
   assign bus_err_o   = !rst & w_timeout;
   assign wd_o        = rst ? '0 : wd_i;
   assign wreg_o      = !rst & wreg_i & !w_req & !w_mis & !(w_done & r_berr);
   assign wdata_o     = rst ? 32'd0 : w_done ? (w_ld ? r_ldata : w_sc ? 32'd1 : wdata_i) : (w_sc & !w_scok) ? 32'd0 : wdata_i;
   assign hi_o        = rst ? 32'd0 : hi_i;
   assign lo_o        = rst ? 32'd0 : lo_i;
   assign whilo_o     = !rst & whilo_i;
endmodule
